// File: rtl/add_nbit_pkg.sv
// add_nbit_pkg: shared types and parameter checks for the serial adder.
// The optional overflow output of add_nbit_serial is enabled by ADD_NBIT_OVF_EN.
package add_nbit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Legal when 1 <= width <= 64 and digit evenly divides width.
    function automatic bit digit_ok(input int unsigned width, input int unsigned digit);
        return (width >= 1) && (width <= 64) &&
               (digit >= 1) && (digit <= width) &&
               ((width % digit) == 0);
    endfunction

endpackage

// File: rtl/add_digit.sv
// add_digit: combinational DIGIT-bit adder slice used by add_nbit_serial.
// c_msb is the carry into the slice's top bit; only ADD_NBIT_OVF_EN builds consume it.
module add_digit #(
    parameter int unsigned DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             c_in,
    output logic [DIGIT-1:0] s,
    output logic             c_out,
    output logic             c_msb
);

    logic [DIGIT:0] total;

    // Full-width add with one extra bit to capture the carry out.
    always_comb begin
        total = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, c_in};
        s     = total[DIGIT-1:0];
        c_out = total[DIGIT];
        // Sum bit = a ^ b ^ carry-in, so the top bit's carry-in is recovered by XOR.
        c_msb = a[DIGIT-1] ^ b[DIGIT-1] ^ total[DIGIT-1];
    end

endmodule

// File: rtl/add_nbit_serial.sv
// add_nbit_serial: digit-serial unsigned adder with valid/ready handshakes.
// Operands are latched on accept, then DIGIT bits are added per cycle,
// low digit first, with the result shifted into sum from the MSB end.
// Define ADD_NBIT_OVF_EN to add the signed-overflow output ovf.
module add_nbit_serial
    import add_nbit_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef ADD_NBIT_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned NUM_DIGITS = WIDTH / DIGIT;
    localparam int unsigned CNT_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(NUM_DIGITS - 1);

    generate
        if (!digit_ok(WIDTH, DIGIT)) begin : g_bad_digit
            $error("add_nbit_serial: WIDTH must be 1..64 and a multiple of DIGIT");
        end
    endgenerate

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic               carry;
    logic [CNT_W-1:0]   cnt;
    logic               last_digit;
    logic [DIGIT-1:0]   digit_sum;
    logic               digit_carry;
    logic [WIDTH-1:0]   sum_next;
`ifdef ADD_NBIT_OVF_EN
    logic               msb_carry;
`else
    logic               unused_msb_carry;
`endif

    assign last_digit = (cnt == LAST_DIGIT);

    add_digit #(
        .DIGIT (DIGIT)
    ) u_add_digit (
        .a     (a_reg[DIGIT-1:0]),
        .b     (b_reg[DIGIT-1:0]),
        .c_in  (carry),
        .s     (digit_sum),
        .c_out (digit_carry),
`ifdef ADD_NBIT_OVF_EN
        .c_msb (msb_carry)
`else
        .c_msb (unused_msb_carry)
`endif
    );

    // Shift the new digit in from the top; a cast keeps DIGIT == WIDTH legal.
    always_comb begin
        sum_next = (sum >> DIGIT) | (WIDTH'(digit_sum) << (WIDTH - DIGIT));
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (last_digit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand capture, per-digit shift/accumulate and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg <= '0;
            b_reg <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
`ifdef ADD_NBIT_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= a;
                        b_reg <= b;
                        carry <= cin;
                        cnt   <= '0;
                    end
                end
                BUSY: begin
                    a_reg <= a_reg >> DIGIT;
                    b_reg <= b_reg >> DIGIT;
                    carry <= digit_carry;
                    sum   <= sum_next;
                    cnt   <= cnt + CNT_W'(1);
                    if (last_digit) begin
                        cout <= digit_carry;
`ifdef ADD_NBIT_OVF_EN
                        ovf  <= msb_carry ^ digit_carry;
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
